// File: rtl/regfile_pkg.sv
// Shared constants and types for the scoreboarded register file.
package regfile_pkg;
   localparam int REG_NUM    = 32;
   localparam int REG_ADDR_W = 5;
   localparam int DEF_DATA_W = 32;
   localparam logic [DEF_DATA_W-1:0] ZERO_WORD = '0;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;
endpackage

// File: rtl/regfile_scoreboard_if.sv
// Writeback, issue-reserve, flush and read-port bundle of the register file.
interface regfile_scoreboard_if
   import regfile_pkg::*;
#(
   parameter int DATA_W  = DEF_DATA_W,
   parameter int NUM_WR  = 2,
   parameter int NUM_RD  = 4,
   parameter int NUM_ISS = 2
);
   logic [NUM_WR-1:0]             wb_we;
   logic [NUM_WR*REG_ADDR_W-1:0]  wb_waddr;
   logic [NUM_WR*DATA_W-1:0]      wb_wdata;
   logic [NUM_ISS-1:0]            iss_valid;
   logic [NUM_ISS*REG_ADDR_W-1:0] iss_waddr;
   logic                          iss_ready;
   logic                          flush;
   logic [NUM_RD-1:0]             rd_re;
   logic [NUM_RD*REG_ADDR_W-1:0]  rd_addr;
   logic [NUM_RD*DATA_W-1:0]      rd_data;
   logic [NUM_RD-1:0]             rd_busy;

   modport master (
      output wb_we, wb_waddr, wb_wdata,
      output iss_valid, iss_waddr, flush,
      output rd_re, rd_addr,
      input  iss_ready, rd_data, rd_busy
   );

   modport slave (
      input  wb_we, wb_waddr, wb_wdata,
      input  iss_valid, iss_waddr, flush,
      input  rd_re, rd_addr,
      output iss_ready, rd_data, rd_busy
   );
endinterface

// File: rtl/rf_pending_ctr.sv
// Saturating pending-write counter for one architectural register.
module rf_pending_ctr #(
   parameter int CNT_W = 2,
   parameter int IN_W  = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [IN_W-1:0]  i_inc,
   input  logic [IN_W-1:0]  i_dec,
   input  logic             i_flush,
   output logic [CNT_W-1:0] o_cnt,
   output logic             o_busy
);
   localparam int MAX = (1 << CNT_W) - 1;

   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_nxt;
   int               w_sum;
   int               w_rem;

   always_comb begin
      w_sum = int'(r_cnt) + int'(i_inc) - int'(i_dec);
      w_rem = int'(r_cnt) - int'(i_dec);
      w_nxt = r_cnt;
      // late writebacks after a flush must not wrap the counter
      if (w_sum < 0)
         w_nxt = '0;
      else if (w_sum > MAX)
         w_nxt = CNT_W'(MAX);
      else
         w_nxt = CNT_W'(w_sum);
      o_busy = (w_rem > 0);
   end

   always_ff @(posedge clk) begin
      if (rst || i_flush)
         r_cnt <= '0;
      else
         r_cnt <= w_nxt;
   end

   assign o_cnt = r_cnt;
endmodule

// File: rtl/regfile_scoreboard.sv
// 32-entry register file with write bypass and per-register pending-write
// scoreboard gating issue of new destination reservations.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int DATA_W  = DEF_DATA_W,
   parameter int NUM_WR  = 2,
   parameter int NUM_RD  = 4,
   parameter int NUM_ISS = 2,
   parameter int CNT_W   = 2
) (
   input logic                 clk,
   input logic                 rst,
   regfile_scoreboard_if.slave bus
);
   localparam int MAX      = (1 << CNT_W) - 1;
   localparam int IN_MAX   = (NUM_ISS > NUM_WR) ? NUM_ISS : NUM_WR;
   localparam int CNT_IN_W = $clog2(IN_MAX + 1);

   logic [DATA_W-1:0] r_mem [REG_NUM];
   logic [CNT_W-1:0]  w_cnt [REG_NUM];
   logic [REG_NUM-1:0] w_busy;
   logic              w_ready;
   int                w_n;

   assign w_cnt[0]  = '0;
   assign w_busy[0] = 1'b0;

   // all-or-nothing; same-cycle writebacks are deliberately not credited
   always_comb begin
      w_ready = !rst;
      w_n     = 0;
      for (int i = 0; i < NUM_ISS; i++) begin
         w_n = 0;
         for (int j = 0; j < NUM_ISS; j++) begin
            if (bus.iss_valid[j] &&
                bus.iss_waddr[j*REG_ADDR_W +: REG_ADDR_W] ==
                bus.iss_waddr[i*REG_ADDR_W +: REG_ADDR_W])
               w_n = w_n + 1;
         end
         if (bus.iss_valid[i] &&
             bus.iss_waddr[i*REG_ADDR_W +: REG_ADDR_W] != '0 &&
             int'(w_cnt[bus.iss_waddr[i*REG_ADDR_W +: REG_ADDR_W]]) + w_n > MAX)
            w_ready = 1'b0;
      end
   end

   assign bus.iss_ready = w_ready;

   for (genvar g = 1; g < REG_NUM; g++) begin : g_ctr
      logic [CNT_IN_W-1:0] w_inc;
      logic [CNT_IN_W-1:0] w_dec;

      always_comb begin
         w_inc = '0;
         w_dec = '0;
         for (int i = 0; i < NUM_ISS; i++) begin
            if (w_ready && bus.iss_valid[i] &&
                bus.iss_waddr[i*REG_ADDR_W +: REG_ADDR_W] == REG_ADDR_W'(g))
               w_inc = w_inc + CNT_IN_W'(1);
         end
         for (int p = 0; p < NUM_WR; p++) begin
            if (bus.wb_we[p] &&
                bus.wb_waddr[p*REG_ADDR_W +: REG_ADDR_W] == REG_ADDR_W'(g))
               w_dec = w_dec + CNT_IN_W'(1);
         end
      end

      rf_pending_ctr #(
         .CNT_W (CNT_W),
         .IN_W  (CNT_IN_W)
      ) u_ctr (
         .clk     (clk),
         .rst     (rst),
         .i_inc   (w_inc),
         .i_dec   (w_dec),
         .i_flush (bus.flush),
         .o_cnt   (w_cnt[g]),
         .o_busy  (w_busy[g])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < REG_NUM; k++)
            r_mem[k] <= '0;
      end else begin
         // ascending loop: the youngest enabled port wins
         for (int p = 0; p < NUM_WR; p++) begin
            if (bus.wb_we[p] &&
                bus.wb_waddr[p*REG_ADDR_W +: REG_ADDR_W] != '0)
               r_mem[bus.wb_waddr[p*REG_ADDR_W +: REG_ADDR_W]] <=
                  bus.wb_wdata[p*DATA_W +: DATA_W];
         end
      end
   end

   for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
      reg_addr_t         w_a;
      logic [DATA_W-1:0] w_d;
      logic              w_b;

      always_comb begin
         w_a = bus.rd_addr[g*REG_ADDR_W +: REG_ADDR_W];
         w_d = '0;
         w_b = 1'b0;
         if (!rst && bus.rd_re[g] && w_a != '0) begin
            w_d = r_mem[w_a];
            for (int p = 0; p < NUM_WR; p++) begin
               if (bus.wb_we[p] &&
                   bus.wb_waddr[p*REG_ADDR_W +: REG_ADDR_W] == w_a)
                  w_d = bus.wb_wdata[p*DATA_W +: DATA_W];
            end
            w_b = w_busy[w_a];
         end
      end

      assign bus.rd_data[g*DATA_W +: DATA_W] = w_d;
      assign bus.rd_busy[g]                  = w_b;
   end
endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 Parameter DATA_W, 32, register width in bits.
REQ-002 Parameter NUM_WR, 2, writeback ports; higher index = younger instruction.
REQ-003 Parameter NUM_RD, 4, read ports.
REQ-004 Parameter NUM_ISS, 2, issue (destination-reserve) ports; higher index = younger.
REQ-005 Parameter CNT_W, 2, width of per-register pending-write counter.
REQ-006 Ports: clk, rst. Reset rst is synchronous and active-high; clock is clk.
REQ-007 wb_we  in  NUM_WR  per-port write enable.
REQ-008 wb_waddr  in  NUM_WR*5  write register index per port.
REQ-009 wb_wdata  in  NUM_WR*DATA_W  write data per port.
REQ-010 iss_valid  in  NUM_ISS  issue slot carries a destination register.
REQ-011 iss_waddr  in  NUM_ISS*5  destination index per issue slot.
REQ-012 iss_ready  out  1  all valid issue slots may be accepted this cycle.
REQ-013 flush  in  1  discard all pending reservations.
REQ-014 rd_re  in  NUM_RD  per-port read enable.
REQ-015 rd_addr  in  NUM_RD*5  read register index per port.
REQ-016 rd_data  out  NUM_RD*DATA_W  read data per port.
REQ-017 rd_busy  out  NUM_RD  read register still has an outstanding write.

Function
REQ-018 32 registers; r0 reads 0, is never written and is never busy.
REQ-019 Writes commit on posedge clk; multiple ports to the same address: highest-index enabled port wins (replaces PC comparison).
REQ-020 Read is combinational: rst=1, rd_re=0 or rd_addr=0 -> 0; else youngest same-cycle matching wb port data (bypass); else array contents.
REQ-021 Each register r1..r31 has a CNT_W-bit pending counter, reset 0, max 2^CNT_W-1.
REQ-022 Issue accepted only when iss_valid[i] && iss_ready; each accepted slot with waddr!=0 increments its destination counter by 1 (two slots to the same reg: +2).
REQ-023 Each wb_we port with waddr!=0 decrements its register's counter by 1; decrements below 0 are clamped (late writeback after flush).
REQ-024 Same-cycle issue and writeback to one register: counter next = cnt + inc - dec, clamped to [0,max].
REQ-025 iss_ready=0 when, for any valid slot, cnt[dest] + valid slots targeting dest this cycle > max; it ignores same-cycle writebacks (conservative) and is all-or-nothing.
REQ-026 rd_busy = rd_re && rd_addr!=0 && (cnt[rd_addr] - same-cycle decrements) > 0; same-cycle issues do not set it.
REQ-027 flush=1: all counters 0 next cycle, overriding same-cycle issue increments; writebacks in that cycle still update the array.
REQ-028 iss_ready and rd_busy are 0 while rst=1.

Reset
REQ-029 rst=1 at posedge clk: all 32 registers and all counters cleared to 0; writes and issues in that cycle are dropped.
REQ-030 Reset mid-operation discards all in-flight reservations; no state survives.

Structure
REQ-031 Package regfile_pkg holds REG_NUM=32, REG_ADDR_W=5, default DATA_W and ZERO_WORD.
REQ-032 Sub-module rf_pending_ctr (one instance per register r1..r31): inc count, dec count, flush, saturating update, busy output.
REQ-033 Data array and bypass muxes stay in the top module; no latches, all read logic one combinational block per port, generated by NUM_RD.

Verification
REQ-034 wb0 r5=0x11, wb1 r5=0x22 same cycle -> r5 reads 0x22 next cycle; same-cycle read of r5 returns 0x22.
REQ-035 Issue r7 (cnt 0->1), read r7 -> rd_busy=1; wb r7=0xAB -> same-cycle rd_busy=0, rd_data=0xAB.
REQ-036 CNT_W=2: issue r3 three times -> cnt=3; next valid issue to r3 -> iss_ready=0, counter unchanged.
REQ-037 Issue r4 with flush=1 -> cnt[r4]=0 next cycle; later wb r4=0x5 -> data written, cnt stays 0.
REQ-038 wb r0=0xFFFF and issue r0 -> r0 reads 0, rd_busy=0, iss_ready unaffected.
REQ-039 Load r9=0x9, issue r9, assert rst one cycle -> r9 reads 0, rd_busy=0, iss_ready=1 after release.
